// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester arbiter: sizes, FSM encodings and
// the request-vector rotation used by round-robin arbitration.
package arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Rotate right by amt: result bit i comes from vec[(i + amt) mod 8].
    function automatic logic [N-1:0] rotr8(input logic [N-1:0] vec,
                                           input logic [IDX_W-1:0] amt);
        logic [2*N-1:0] dbl_s;
        dbl_s = {vec, vec} >> amt;
        return dbl_s[N-1:0];
    endfunction

endpackage

// File: rtl/prio_enc_8to3.sv
// 8-to-3 priority encoder, in[7] highest; idx is 0 and any is 0 for an empty input.
module prio_enc_8to3
    import arb_pkg::*;
(
    input  logic [N-1:0]     in,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Highest set bit wins.
    always_comb begin
        idx = 3'd0;
        casez (in)
            8'b1???_????: idx = 3'd7;
            8'b01??_????: idx = 3'd6;
            8'b001?_????: idx = 3'd5;
            8'b0001_????: idx = 3'd4;
            8'b0000_1???: idx = 3'd3;
            8'b0000_01??: idx = 3'd2;
            8'b0000_001?: idx = 3'd1;
            8'b0000_0001: idx = 3'd0;
            default:      idx = 3'd0;
        endcase
    end

    assign any = |in;

endmodule

// File: rtl/req_arbiter_8.sv
// 8-requester arbiter: fixed-priority or round-robin selection, grant held until
// done, request drop or MAX_HOLD cycles, with a one-cycle timeout pulse.
module req_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [N-1:0]     req,
    input  logic             done,
    input  logic             rr_en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int                CNT_W      = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_LIMIT = CNT_W'(MAX_HOLD);

    arb_state_e       state_r, state_nx_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_nx_s;
    logic [IDX_W-1:0] last_idx_r, last_nx_s;
    logic [N-1:0]     gnt_nx_s;
    logic [IDX_W-1:0] idx_nx_s;
    logic             valid_nx_s;
    logic             timeout_nx_s;

    logic [N-1:0]     enc_in_s;
    logic [IDX_W-1:0] enc_idx_s;
    logic             enc_any_s;
    logic [IDX_W-1:0] winner_s;
    logic             at_limit_s;
    logic             owner_req_s;
    logic             release_s;

    // Rotating by last_idx puts last_idx-1 on bit 7 and last_idx itself on bit 0,
    // so the plain encoder yields round-robin order; adding last_idx maps back.
    always_comb begin
        if (rr_en) begin
            enc_in_s = rotr8(req, last_idx_r);
            winner_s = enc_idx_s + last_idx_r;
        end else begin
            enc_in_s = req;
            winner_s = enc_idx_s;
        end
    end

    prio_enc_8to3 u_enc (
        .in  (enc_in_s),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    assign at_limit_s  = (hold_cnt_r == HOLD_LIMIT);
    assign owner_req_s = req[gnt_idx];
    assign release_s   = done | ~owner_req_s | at_limit_s;

    // Next-state and next-output logic.
    always_comb begin
        state_nx_s   = state_r;
        gnt_nx_s     = gnt;
        idx_nx_s     = gnt_idx;
        valid_nx_s   = gnt_valid;
        timeout_nx_s = 1'b0;
        hold_nx_s    = hold_cnt_r;
        last_nx_s    = last_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (enc_any_s) begin
                    state_nx_s = ST_GRANT;
                    gnt_nx_s   = 8'd1 << winner_s;
                    idx_nx_s   = winner_s;
                    valid_nx_s = 1'b1;
                    last_nx_s  = winner_s;
                    hold_nx_s  = CNT_W'(1);
                end else begin
                    gnt_nx_s   = 8'd0;
                    idx_nx_s   = 3'd0;
                    valid_nx_s = 1'b0;
                    hold_nx_s  = '0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_nx_s   = ST_IDLE;
                    gnt_nx_s     = 8'd0;
                    idx_nx_s     = 3'd0;
                    valid_nx_s   = 1'b0;
                    hold_nx_s    = '0;
                    timeout_nx_s = at_limit_s & ~done & owner_req_s;
                end else if (!at_limit_s) begin
                    hold_nx_s = hold_cnt_r + CNT_W'(1);
                end else begin
                    hold_nx_s = hold_cnt_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                gnt_nx_s   = 8'd0;
                idx_nx_s   = 3'd0;
                valid_nx_s = 1'b0;
                hold_nx_s  = '0;
            end
        endcase
    end

    // State, counter, round-robin pointer and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            last_idx_r <= 3'd0;
            gnt        <= 8'd0;
            gnt_idx    <= 3'd0;
            gnt_valid  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            hold_cnt_r <= hold_nx_s;
            last_idx_r <= last_nx_s;
            gnt        <= gnt_nx_s;
            gnt_idx    <= idx_nx_s;
            gnt_valid  <= valid_nx_s;
            timeout    <= timeout_nx_s;
        end
    end

endmodule
